fp_add_scheduler: RTL

//  Shares one multi-cycle single-precision floating-point adder between NREQ requesters.

---
 rtl/fp_add_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/fp_add_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants and FSM state encoding for the floating-point adder scheduler.
package fp_add_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] winner,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        winner      = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one multi-cycle FP adder between NREQ requesters with round-robin grants.
// Optional watchdog abort of a stuck adder operation: define FPADD_WATCHDOG_EN.
module fp_add_scheduler
  import fp_add_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
`ifdef FPADD_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*FP_W-1:0] req_x,
  input  logic [NREQ*FP_W-1:0] req_y,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [FP_W-1:0]      rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 fpu_start,
  output logic [FP_W-1:0]      fpu_x,
  output logic [FP_W-1:0]      fpu_y,
  input  logic                 fpu_done,
  input  logic [FP_W-1:0]      fpu_result,
  input  logic                 fpu_overflow
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, id_q, rsp_id_q;
  logic [FP_W-1:0] x_q, y_q, res_q;
  logic            ovf_q;

  logic [NREQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_winner, ptr_next;
  logic            arb_any, take, fin_ok;

  rr_arbiter #(
    .NREQ(NREQ),
    .ID_W(ID_W)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_grant),
    .winner (arb_winner),
    .any    (arb_any)
  );

  assign take     = (state_q == StIdle) && arb_any;
  assign ptr_next = (arb_winner == ID_W'(NREQ - 1)) ? '0 : arb_winner + 1'b1;

`ifdef FPADD_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q;
  logic            err_q, fin_err;
`endif

  always_comb begin
    state_d = state_q;
    fin_ok  = 1'b0;
`ifdef FPADD_WATCHDOG_EN
    fin_err = 1'b0;
`endif
    unique case (state_q)
      StIdle:  if (arb_any) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (fpu_done) begin
          state_d = StResp;
          fin_ok  = 1'b1;
        end
`ifdef FPADD_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = StResp;
          fin_err = 1'b1;
        end
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rsp_id_q <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef FPADD_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (take) begin
        x_q      <= req_x[arb_winner*FP_W +: FP_W];
        y_q      <= req_y[arb_winner*FP_W +: FP_W];
        id_q     <= arb_winner;
        rr_ptr_q <= ptr_next;
      end
      // Response fields are separate from id_q so they hold across the next grant.
      if (fin_ok) begin
        rsp_id_q <= id_q;
        res_q    <= fpu_result;
        ovf_q    <= fpu_overflow;
      end
`ifdef FPADD_WATCHDOG_EN
      wd_q <= (state_q == StWait) ? wd_q + 1'b1 : '0;
      if (fin_ok) err_q <= 1'b0;
      if (fin_err) begin
        rsp_id_q <= id_q;
        res_q    <= QNAN;
        ovf_q    <= 1'b0;
        err_q    <= 1'b1;
      end
`endif
    end
  end

  assign gnt          = (take && !reset) ? arb_grant : '0;
  assign fpu_start    = (state_q == StIssue);
  assign rsp_valid    = (state_q == StResp);
  assign busy         = (state_q != StIdle);
  assign fpu_x        = x_q;
  assign fpu_y        = y_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;
`ifdef FPADD_WATCHDOG_EN
  assign rsp_err      = err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule
